// File: rtl/axis_i2s_pkg.sv
// Shared widths and parameter legality helpers for the I2S master and its clock generator.
package axis_i2s_pkg;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   function automatic int chan_width(input int tdata_width);
      return tdata_width / 2;
   endfunction

   function automatic int bit_cntr_width(input int slot_width);
      return clog2(2 * slot_width);
   endfunction

   function automatic int div_cntr_width(input int bclk_div);
      return clog2(bclk_div);
   endfunction

   function automatic bit params_legal(input int tdata_width, input int bclk_div, input int slot_width);
      return (tdata_width % 2 == 0) && (tdata_width >= 4) && (bclk_div >= 4) &&
             (slot_width >= chan_width(tdata_width) + 1);
   endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// BCLK divider and frame bit counter; strobes are combinational in the terminal-count cycle,
// and slot_bit/right describe the bit position that applies once that cycle's edge is taken.
module i2s_clk_gen
   import axis_i2s_pkg::*;
#(
   parameter int BCLK_DIV   = 8,
   parameter int SLOT_WIDTH = 32
)(
   input  logic                                  aclk,
   input  logic                                  aresetn,
   input  logic                                  enable_i,
   output logic                                  bclk_o,
   output logic                                  lrclk_o,
   output logic                                  fall_o,
   output logic                                  rise_o,
   output logic                                  frame_start_o,
   output logic                                  right_o,
   output logic [bit_cntr_width(SLOT_WIDTH)-1:0] slot_bit_o
);

   localparam int DW = div_cntr_width(BCLK_DIV);
   localparam int BW = bit_cntr_width(SLOT_WIDTH);
   localparam logic [DW-1:0] DIV_TC   = DW'(BCLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_WIDTH - 1);
   localparam logic [BW-1:0] SLOT_B   = BW'(SLOT_WIDTH);

   logic [DW-1:0] div_q, div_d;
   logic [BW-1:0] bit_q, bit_d;
   logic          bclk_q, bclk_d;
   logic          lrclk_q, lrclk_d;
   logic          tc;

   always_comb begin
      tc            = enable_i && (div_q == DIV_TC);
      div_d         = tc ? '0 : div_q + DW'(1);
      bclk_d        = tc ? ~bclk_q : bclk_q;
      fall_o        = tc && bclk_q;
      rise_o        = tc && !bclk_q;
      bit_d         = bit_q;
      if (fall_o) bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + BW'(1);
      right_o       = (bit_d >= SLOT_B);
      slot_bit_o    = right_o ? bit_d - SLOT_B : bit_d;
      lrclk_d       = fall_o ? right_o : lrclk_q;
      frame_start_o = fall_o && (bit_d == '0);
   end

   // Idle state parks the bit counter on the last slot bit so the first fall opens a frame.
   always_ff @(posedge aclk) begin
      if (!aresetn || !enable_i) begin
         div_q   <= '0;
         bit_q   <= BIT_LAST;
         bclk_q  <= 1'b0;
         lrclk_q <= 1'b0;
      end else begin
         div_q   <= div_d;
         bit_q   <= bit_d;
         bclk_q  <= bclk_d;
         lrclk_q <= lrclk_d;
      end
   end

   assign bclk_o  = bclk_q;
   assign lrclk_o = lrclk_q;

endmodule

// File: rtl/axis_i2s_master.sv
// I2S bus master: AXIS stereo words out on SDOUT, SDIN back to AXIS; one DAC word taken per frame,
// ADC output is a single register that is overwritten (with adc_overflow) when not drained in time.
module axis_i2s_master
   import axis_i2s_pkg::*;
#(
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int BCLK_DIV         = 8,
   parameter int SLOT_WIDTH       = 32
)(
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic                        enable,
   output logic                        i2s_bclk,
   output logic                        i2s_lrclk,
   output logic                        i2s_sdout,
   input  logic                        i2s_sdin,
   output logic                        s_axis_tready,
   input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic                        s_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                        m_axis_tvalid,
   output logic                        dac_underflow,
   output logic                        adc_overflow
);

   localparam int W  = chan_width(AXIS_TDATA_WIDTH);
   localparam int BW = bit_cntr_width(SLOT_WIDTH);
   localparam int CW = clog2(W);
   localparam logic [BW-1:0] W_B = BW'(W);
   localparam bit PARAMS_OK = params_legal(AXIS_TDATA_WIDTH, BCLK_DIV, SLOT_WIDTH);

   if (!PARAMS_OK) begin : g_param_check
      $error("axis_i2s_master: illegal AXIS_TDATA_WIDTH/BCLK_DIV/SLOT_WIDTH combination");
   end

   logic          bclk, lrclk, fall, rise, frame_start, right;
   logic [BW-1:0] slot_bit;

   i2s_clk_gen #(
      .BCLK_DIV   (BCLK_DIV),
      .SLOT_WIDTH (SLOT_WIDTH)
   ) u_clk_gen (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .enable_i      (enable),
      .bclk_o        (bclk),
      .lrclk_o       (lrclk),
      .fall_o        (fall),
      .rise_o        (rise),
      .frame_start_o (frame_start),
      .right_o       (right),
      .slot_bit_o    (slot_bit)
   );

   logic                        sdout_q, sdout_d;
   logic                        tready_q, tready_d;
   logic                        underflow_q, underflow_d;
   logic                        overflow_q, overflow_d;
   logic                        tvalid_q, tvalid_d;
   logic [AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
   logic [AXIS_TDATA_WIDTH-1:0] dac_word_q, dac_word_d;
   logic [W-1:0]                shift_q, shift_d;
   logic [W-1:0]                left_hold_q, left_hold_d;
   logic                        sdin_s1_q, sdin_s2_q;

   logic [W-1:0]  chan_word;
   logic [W-1:0]  shift_nxt;
   logic [CW-1:0] bit_idx;
   logic          data_bit;

   always_comb begin
      sdout_d     = sdout_q;
      tready_d    = frame_start;
      underflow_d = 1'b0;
      overflow_d  = 1'b0;
      dac_word_d  = dac_word_q;
      shift_d     = shift_q;
      left_hold_d = left_hold_q;
      tdata_d     = tdata_q;
      tvalid_d    = tvalid_q;
      chan_word   = right ? dac_word_q[W-1:0] : dac_word_q[2*W-1:W];
      bit_idx     = CW'(W_B - slot_bit);
      data_bit    = (slot_bit != '0) && (slot_bit <= W_B);
      shift_nxt   = {shift_q[W-2:0], sdin_s2_q};

      // The accept cycle is the registered tready, so capture lines up with the AXIS handshake.
      if (tready_q) begin
         if (s_axis_tvalid) begin
            dac_word_d = s_axis_tdata;
         end else begin
            dac_word_d  = '0;
            underflow_d = 1'b1;
         end
      end

      if (fall) sdout_d = data_bit & chan_word[bit_idx];
      if (rise && data_bit) shift_d = shift_nxt;

      if (tvalid_q && m_axis_tready) tvalid_d = 1'b0;
      if (rise && (slot_bit == W_B)) begin
         if (!right) begin
            left_hold_d = shift_nxt;
         end else begin
            tdata_d    = {left_hold_q, shift_nxt};
            tvalid_d   = 1'b1;
            overflow_d = tvalid_q && !m_axis_tready;
         end
      end

      if (!enable) begin
         sdout_d     = 1'b0;
         shift_d     = '0;
         left_hold_d = '0;
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         sdout_q     <= 1'b0;
         tready_q    <= 1'b0;
         underflow_q <= 1'b0;
         overflow_q  <= 1'b0;
         tvalid_q    <= 1'b0;
         tdata_q     <= '0;
         dac_word_q  <= '0;
         shift_q     <= '0;
         left_hold_q <= '0;
         sdin_s1_q   <= 1'b0;
         sdin_s2_q   <= 1'b0;
      end else begin
         sdout_q     <= sdout_d;
         tready_q    <= tready_d;
         underflow_q <= underflow_d;
         overflow_q  <= overflow_d;
         tvalid_q    <= tvalid_d;
         tdata_q     <= tdata_d;
         dac_word_q  <= dac_word_d;
         shift_q     <= shift_d;
         left_hold_q <= left_hold_d;
         sdin_s1_q   <= i2s_sdin;
         sdin_s2_q   <= sdin_s1_q;
      end
   end

   assign i2s_bclk      = bclk;
   assign i2s_lrclk     = lrclk;
   assign i2s_sdout     = sdout_q;
   assign s_axis_tready = tready_q;
   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign dac_underflow = underflow_q;
   assign adc_overflow  = overflow_q;

endmodule

// File: doc/axis_i2s_master.md
Name: axis_i2s_master

Overview:
- I2S bus master transceiver. It generates BCLK and LRCLK from aclk and drives the codec, which acts as an I2S slave.
- Serialises stereo DAC words from an AXI4-Stream slave onto SDOUT.
- Deserialises SDIN into stereo ADC words on an AXI4-Stream master.
- It is the clock-owning counterpart of our existing I2S slave receiver/transmitter, for boards where the FPGA, not the codec, is the I2S master.

Parameters:
- AXIS_TDATA_WIDTH, 32, stereo word width. W = AXIS_TDATA_WIDTH/2 bits per channel. Must be even and >= 4.
- BCLK_DIV, 8, aclk cycles per BCLK half-period. Must be >= 4. BCLK period = 2*BCLK_DIV aclk cycles.
- SLOT_WIDTH, 32, BCLK periods per channel slot. Must be >= W+1.

Ports:
- aclk  in  1  system clock
- aresetn  in  1  synchronous active-low reset
- enable  in  1  run control; low = bus idle
- i2s_bclk  out  1  bit clock
- i2s_lrclk  out  1  word select; 0 = left, 1 = right
- i2s_sdout  out  1  DAC serial data
- i2s_sdin  in  1  ADC serial data (asynchronous to aclk)
- s_axis_tready  out  1  DAC sample accept strobe
- s_axis_tdata  in  AXIS_TDATA_WIDTH  DAC word; [2W-1:W] = left, [W-1:0] = right
- s_axis_tvalid  in  1
- m_axis_tready  in  1
- m_axis_tdata  out  AXIS_TDATA_WIDTH  ADC word, same packing as the DAC word
- m_axis_tvalid  out  1
- dac_underflow  out  1  one-cycle pulse
- adc_overflow  out  1  one-cycle pulse

Behaviour:
- Reset and outputs:
  - Reset is synchronous, active-low, on aresetn; clock is aclk.
  - Every output is a register.
  - Reset values: bclk=0, lrclk=0, sdout=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, both pulses 0, div_cntr=0, bit_cntr=2*SLOT_WIDTH-1, dac_word=0.
- Divider:
  - div_cntr counts 0..BCLK_DIV-1 while enable=1.
  - At terminal count: bclk toggles, div_cntr returns to 0.
  - A toggle from bclk 1→0 is a FALL event; 0→1 is a RISE event. Events are evaluated in the terminal-count cycle, so outputs update in the same aclk cycle as the bclk edge.
- Bit counter:
  - On FALL, bit_cntr increments modulo 2*SLOT_WIDTH.
  - Slot index b = bit_cntr mod SLOT_WIDTH.
  - lrclk = (bit_cntr >= SLOT_WIDTH), updated on FALL.
  - The first FALL after reset or enable wraps bit_cntr to 0: frame start, left slot.
- DAC path:
  - On a FALL that wraps bit_cntr to 0, s_axis_tready=1 for exactly that aclk cycle; otherwise it is 0.
  - If s_axis_tvalid is high: dac_word <= s_axis_tdata.
  - Else: dac_word <= 0 and dac_underflow pulses.
  - On every FALL, sdout is driven from the new b:
    - 1 <= b <= W: dac_word bit (W-b) of the current channel half, MSB first.
    - b = 0 or b > W: sdout = 0.
  - Result: the MSB appears one BCLK after the LRCLK edge (I2S standard).
- ADC path:
  - i2s_sdin passes through a 2-flop synchroniser.
  - On RISE with 1 <= b <= W, the synchronised bit shifts into a W-bit shift register, MSB first.
  - On RISE with b = W:
    - Left slot: the shift register is copied to left_hold.
    - Right slot: m_axis_tdata <= {left_hold, shift register} and m_axis_tvalid <= 1.
  - m_axis_tvalid clears in the cycle after m_axis_tready && m_axis_tvalid.
  - If a new word completes while m_axis_tvalid=1 and m_axis_tready=0: the word overwrites m_axis_tdata, tvalid stays 1, and adc_overflow pulses.
  - If tready handshake and word completion coincide: the new word loads and tvalid stays 1, with no overflow.
- enable=0:
  - Takes effect in the next cycle.
  - bclk, lrclk and sdout are forced to 0.
  - div_cntr=0; bit_cntr=2*SLOT_WIDTH-1; the ADC shift register and left_hold are cleared.
  - m_axis_tdata/tvalid are held; a pending word is still handed over.
  - Re-enable restarts at a clean frame boundary.
- Reset mid-frame: everything returns to reset values next cycle. No partial word is emitted.

Decomposition:
- Package axis_i2s_pkg holds:
  - the W derivation
  - the bit_cntr width function clog2(2*SLOT_WIDTH)
  - the div_cntr width function clog2(BCLK_DIV)
  - parameter legality checks as constants
- Sub-module i2s_clk_gen (divider + bit counter, emitting bclk, lrclk, fall/rise/frame_start strobes and b). It is reusable by a future TDM master.

Test Plan:
- Clocking: defaults, enable=1 from reset. Expect:
  - bclk period 16 aclk cycles
  - lrclk period 64 BCLK (1024 aclk)
  - first s_axis_tready pulse on the first BCLK fall
  - lrclk low for 32 BCLK, then high for 32
- DAC serialisation: supply 0xA5A5_3C3C held valid. Expect:
  - sdout on BCLK falls 1..16 of the left slot = 0xA5A5, MSB first
  - falls 1..16 of the right slot = 0x3C3C
  - bits 0 and 17..31 of each slot = 0
- Loopback: sdout tied to sdin, m_axis_tready=1. Expect m_axis_tdata = 0xA5A5_3C3C with one tvalid per frame.
- Underflow: s_axis_tvalid=0 at frame start. Expect dac_underflow pulse, an all-zero frame on sdout, and tready still pulsing.
- Backpressure: m_axis_tready=0 for 3 frames. Expect tvalid held high, 2 adc_overflow pulses, and tdata = the last frame's word.
- Stop/restart: deassert enable mid right slot, then reassert. Expect:
  - bclk, lrclk and sdout at 0 next cycle
  - on restart, a new frame start with the tready pulse on the first fall
  - no spurious m_axis_tvalid
- Reset mid-frame: same expectations.
